// File: rtl/rv32i_arb_pkg.sv
// Shared definitions for the RV32I instruction/data memory arbiter:
// FSM encodings, owner tags for outstanding reads, and the fetch byte-enable.
package rv32i_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  localparam logic [3:0] I_FETCH_BYTEENABLE = 4'hF;

endpackage

// File: rtl/rv32i_arb_tag_fifo.sv
// Owner-tag FIFO: one bit per read issued to the slave, popped as the
// in-order responses come back so each response reaches the right master.
module rv32i_arb_tag_fifo #(
  parameter int LOG2_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DEPTH-1:0]      mem_q, mem_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  // Count never exceeds DEPTH, so its MSB alone signals full.
  assign full  = count_q[LOG2_DEPTH];
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Two-master (instruction fetch, load/store) to one-slave Avalon-MM arbiter
// with zero-latency grant, stall locking and in-order read response routing.
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int DATA_PRIORITY        = 0,
  parameter int LOG2_MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readdatavalid,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readdatavalid,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        rsp_error
);

  // Handshake: a command transfers in any cycle where m_read|m_write is high
  // and m_waitrequest is low; a requester sees waitrequest low only then.

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic       rsp_error_q, rsp_error_d;

  logic fifo_full, fifo_empty, fifo_head;
  logic rd_ok, elig_i, elig_d;
  logic gnt_i, gnt_d;
  logic accept, push, pop;

  rv32i_arb_tag_fifo #(
    .LOG2_DEPTH(LOG2_MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (gnt_d),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    rd_ok  = ~fifo_full;
    elig_i = i_read & rd_ok;
    elig_d = d_write | (d_read & rd_ok);
    gnt_i  = 1'b0;
    gnt_d  = 1'b0;
    case (state_q)
      ARB_LOCK_I: gnt_i = 1'b1;
      ARB_LOCK_D: gnt_d = 1'b1;
      default: begin
        if (elig_i && elig_d) begin
          // rr_q holds the last master granted; the other one wins now.
          if ((DATA_PRIORITY != 0) || (rr_q == TAG_I)) gnt_d = 1'b1;
          else                                         gnt_i = 1'b1;
        end else begin
          gnt_i = elig_i;
          gnt_d = elig_d;
        end
      end
    endcase
    if (reset) begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end

    m_address     = gnt_i ? i_address : d_address;
    m_writedata   = d_writedata;
    m_byteenable  = gnt_i ? I_FETCH_BYTEENABLE : d_byteenable;
    m_read        = ((gnt_i & i_read) | (gnt_d & d_read)) & rd_ok;
    m_write       = gnt_d & d_write;
    accept        = (m_read | m_write) & ~m_waitrequest;
    i_waitrequest = ~(gnt_i & accept);
    d_waitrequest = ~(gnt_d & accept);

    state_d = state_q;
    if (accept || !(m_read || m_write)) state_d = ARB_IDLE;
    else if (gnt_i)                     state_d = ARB_LOCK_I;
    else if (gnt_d)                     state_d = ARB_LOCK_D;

    rr_d = rr_q;
    if (accept) rr_d = gnt_d ? TAG_D : TAG_I;

    push        = accept & m_read;
    pop         = m_readdatavalid & ~fifo_empty;
    rsp_error_d = rsp_error_q | (m_readdatavalid & fifo_empty);

    i_readdata      = m_readdata;
    d_readdata      = m_readdata;
    i_readdatavalid = pop & (fifo_head == TAG_I) & ~reset;
    d_readdatavalid = pop & (fifo_head == TAG_D) & ~reset;
    rsp_error       = rsp_error_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_q        <= TAG_D;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: instance 0 runs round robin, instance 1 data
// priority; master inputs are shared, each instance has its own slave inputs.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, d_address, d_writedata;
  logic        i_read, d_read, d_write;
  logic [3:0]  d_byteenable;

  logic        m_waitrequest [2];
  logic        m_readdatavalid [2];
  logic [31:0] m_readdata [2];

  logic        i_waitrequest [2], i_readdatavalid [2];
  logic        d_waitrequest [2], d_readdatavalid [2];
  logic [31:0] i_readdata [2], d_readdata [2];
  logic [31:0] m_address [2], m_writedata [2];
  logic [3:0]  m_byteenable [2];
  logic        m_read [2], m_write [2], rsp_error [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.DATA_PRIORITY(0), .LOG2_MAX_OUTSTANDING(2)) dut_rr (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest[0]),
    .i_readdata(i_readdata[0]), .i_readdatavalid(i_readdatavalid[0]),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest[0]), .d_readdata(d_readdata[0]),
    .d_readdatavalid(d_readdatavalid[0]),
    .m_address(m_address[0]), .m_read(m_read[0]), .m_write(m_write[0]),
    .m_writedata(m_writedata[0]), .m_byteenable(m_byteenable[0]),
    .m_waitrequest(m_waitrequest[0]), .m_readdata(m_readdata[0]),
    .m_readdatavalid(m_readdatavalid[0]), .rsp_error(rsp_error[0])
  );

  rv32i_mem_arbiter #(.DATA_PRIORITY(1), .LOG2_MAX_OUTSTANDING(2)) dut_dp (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest[1]),
    .i_readdata(i_readdata[1]), .i_readdatavalid(i_readdatavalid[1]),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest[1]), .d_readdata(d_readdata[1]),
    .d_readdatavalid(d_readdatavalid[1]),
    .m_address(m_address[1]), .m_read(m_read[1]), .m_write(m_write[1]),
    .m_writedata(m_writedata[1]), .m_byteenable(m_byteenable[1]),
    .m_waitrequest(m_waitrequest[1]), .m_readdata(m_readdata[1]),
    .m_readdatavalid(m_readdatavalid[1]), .rsp_error(rsp_error[1])
  );

  // Control view: {m_read, m_write, i_wait, d_wait, i_rdv, d_rdv, rsp_error}
  function automatic logic [6:0] ctl(input int k);
    return {m_read[k], m_write[k], i_waitrequest[k], d_waitrequest[k],
            i_readdatavalid[k], d_readdatavalid[k], rsp_error[k]};
  endfunction

  // ---------------- clock / reset / driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0;
    d_writedata = '0; d_byteenable = '0;
    for (int k = 0; k < 2; k++) begin
      m_waitrequest[k] = 1'b0; m_readdatavalid[k] = 1'b0; m_readdata[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] data);
    for (int k = 0; k < 2; k++) begin
      m_readdatavalid[k] = v; m_readdata[k] = data;
    end
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    i_read = 1'b1; d_write = 1'b1; d_address = 32'h55;
    set_rsp(1'b1, 32'h77);
    tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b0011000) begin
        fails++; $display("FAIL reset_ctl[%0d] got %b exp %b", k, ctl(k), 7'b0011000);
      end
    end
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    i_read = 1'b1; i_address = 32'h100;
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b1001000) begin
        fails++; $display("FAIL single_issue_ctl[%0d] got %b exp %b", k, ctl(k), 7'b1001000);
      end
      tests++;
      if (m_address[k] !== 32'h100 || m_byteenable[k] !== 4'hF) begin
        fails++; $display("FAIL single_issue_addr[%0d] got %h/%h exp 100/f", k, m_address[k], m_byteenable[k]);
      end
    end
    tick();
    i_read = 1'b0;
    tick();
    set_rsp(1'b1, 32'h00000013);
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b0011100 || i_readdata[k] !== 32'h13) begin
        fails++; $display("FAIL single_rsp[%0d] got %b/%h exp %b/13", k, ctl(k), i_readdata[k], 7'b0011100);
      end
    end
    tick();
    set_rsp(1'b0, '0);
  endtask

  task automatic test_priority();
    do_reset();
    i_read = 1'b1; i_address = 32'h40;
    d_write = 1'b1; d_address = 32'h2000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'h3;
    settle();
    tests++;
    if (ctl(1) !== 7'b0110000 || m_address[1] !== 32'h2000 ||
        m_writedata[1] !== 32'hDEADBEEF || m_byteenable[1] !== 4'h3) begin
      fails++; $display("FAIL prio_d_first got %b %h %h %h exp %b 2000 deadbeef 3",
                        ctl(1), m_address[1], m_writedata[1], m_byteenable[1], 7'b0110000);
    end
    tests++;
    if (ctl(0) !== 7'b1001000 || m_address[0] !== 32'h40) begin
      fails++; $display("FAIL rr_i_first got %b %h exp %b 40", ctl(0), m_address[0], 7'b1001000);
    end
    tick();
    d_write = 1'b0;
    settle();
    tests++;
    if (ctl(1) !== 7'b1001000 || m_address[1] !== 32'h40 || m_byteenable[1] !== 4'hF) begin
      fails++; $display("FAIL prio_i_second got %b %h %h exp %b 40 f",
                        ctl(1), m_address[1], m_byteenable[1], 7'b1001000);
    end
    tick();
    i_read = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_i;
    do_reset();
    i_read = 1'b1; i_address = 32'h300;
    d_write = 1'b1; d_address = 32'h4000; d_writedata = 32'h1234; d_byteenable = 4'hF;
    for (int c = 0; c < 6; c++) begin
      settle();
      exp_i = (c % 2 == 0);
      tests++;
      if ({m_read[0], m_write[0]} !== {exp_i, ~exp_i}) begin
        fails++; $display("FAIL rr_order c%0d got %b exp %b", c, {m_read[0], m_write[0]}, {exp_i, ~exp_i});
      end
      tests++;
      if ({m_read[1], m_write[1]} !== 2'b01) begin
        fails++; $display("FAIL prio_always_d c%0d got %b exp 01", c, {m_read[1], m_write[1]});
      end
      tick();
    end
    i_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 2; k++) m_waitrequest[k] = 1'b1;
    d_read = 1'b1; d_address = 32'h3000; d_byteenable = 4'hC;
    i_read = 1'b1; i_address = 32'h44;
    for (int c = 0; c < 3; c++) begin
      settle();
      tests++;
      if (ctl(1) !== 7'b1011000 || m_address[1] !== 32'h3000 || m_byteenable[1] !== 4'hC) begin
        fails++; $display("FAIL lock_d c%0d got %b %h %h exp %b 3000 c",
                          c, ctl(1), m_address[1], m_byteenable[1], 7'b1011000);
      end
      tests++;
      if (ctl(0) !== 7'b1011000 || m_address[0] !== 32'h44) begin
        fails++; $display("FAIL lock_i c%0d got %b %h exp %b 44", c, ctl(0), m_address[0], 7'b1011000);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) m_waitrequest[k] = 1'b0;
    settle();
    tests++;
    if (ctl(1) !== 7'b1010000 || m_address[1] !== 32'h3000) begin
      fails++; $display("FAIL lock_d_accept got %b %h exp %b 3000", ctl(1), m_address[1], 7'b1010000);
    end
    tests++;
    if (ctl(0) !== 7'b1001000) begin
      fails++; $display("FAIL lock_i_accept got %b exp %b", ctl(0), 7'b1001000);
    end
    tick();
    d_read = 1'b0;
    settle();
    tests++;
    if (ctl(1) !== 7'b1001000 || m_address[1] !== 32'h44) begin
      fails++; $display("FAIL lock_then_i got %b %h exp %b 44", ctl(1), m_address[1], 7'b1001000);
    end
    tick();
    i_read = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    i_read = 1'b1;
    for (int c = 0; c < 4; c++) begin
      i_address = 32'h200 + 32'(4 * c);
      settle();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ctl(k) !== 7'b1001000) begin
          fails++; $display("FAIL fill c%0d[%0d] got %b exp %b", c, k, ctl(k), 7'b1001000);
        end
      end
      tick();
    end
    set_rsp(1'b1, 32'hA5);
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b0011100) begin
        fails++; $display("FAIL full_blocks_read[%0d] got %b exp %b", k, ctl(k), 7'b0011100);
      end
    end
    tick();
    set_rsp(1'b0, '0);
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b1001000) begin
        fails++; $display("FAIL read_after_pop[%0d] got %b exp %b", k, ctl(k), 7'b1001000);
      end
    end
    tick();
    d_write = 1'b1; d_address = 32'h8000; d_writedata = 32'hCAFE; d_byteenable = 4'h1;
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b0110000 || m_writedata[k] !== 32'hCAFE) begin
        fails++; $display("FAIL write_when_full[%0d] got %b %h exp %b cafe", k, ctl(k), m_writedata[k], 7'b0110000);
      end
    end
    tick();
    i_read = 1'b0; d_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_rsp(1'b1, 32'h600 + 32'(c));
      settle();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ctl(k) !== 7'b0011100) begin
          fails++; $display("FAIL drain c%0d[%0d] got %b exp %b", c, k, ctl(k), 7'b0011100);
        end
      end
      tick();
    end
    set_rsp(1'b0, '0);
  endtask

  task automatic test_order_reset();
    logic [6:0] exp_issue [3];
    logic [6:0] exp_rsp [3];
    exp_issue[0] = 7'b1001000; exp_issue[1] = 7'b1010000; exp_issue[2] = 7'b1001000;
    exp_rsp[0]   = 7'b0011100; exp_rsp[1]   = 7'b0011010; exp_rsp[2]   = 7'b0011100;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      i_read = (c != 1); d_read = (c == 1);
      i_address = 32'h900 + 32'(c); d_address = 32'hA00;
      settle();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ctl(k) !== exp_issue[c]) begin
          fails++; $display("FAIL order_issue c%0d[%0d] got %b exp %b", c, k, ctl(k), exp_issue[c]);
        end
      end
      tick();
    end
    i_read = 1'b0; d_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_rsp(1'b1, 32'h1000 + 32'(c));
      settle();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ctl(k) !== exp_rsp[c] || d_readdata[k] !== 32'h1000 + 32'(c)) begin
          fails++; $display("FAIL order_rsp c%0d[%0d] got %b/%h exp %b/%h",
                            c, k, ctl(k), d_readdata[k], exp_rsp[c], 32'h1000 + 32'(c));
        end
      end
      tick();
    end
    set_rsp(1'b0, '0);
    i_read = 1'b1;
    tick();
    tick();
    i_read = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_rsp(1'b1, 32'hBAD);
    settle();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (ctl(k) !== 7'b0011000) begin
        fails++; $display("FAIL late_rsp_dropped[%0d] got %b exp %b", k, ctl(k), 7'b0011000);
      end
    end
    tick();
    set_rsp(1'b0, '0);
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (ctl(k) !== 7'b0011001) begin
          fails++; $display("FAIL rsp_error_sticky c%0d[%0d] got %b exp %b", c, k, ctl(k), 7'b0011001);
        end
      end
      tick();
    end
  endtask

  // ---------------- randomized test with reference model ----------------
  // Model: per instance a queue of owners of outstanding reads, the master
  // currently holding the bus (0 none, 1 I, 2 D), the last winner, and the
  // sticky error flag.
  bit mq [2][$];
  int m_lock [2];
  int m_last [2];
  bit m_err [2];

  task automatic test_random();
    bit cap, rd, wr, acc, iv, dv, ei, ed;
    int g;
    logic [6:0] exp_c;
    logic [31:0] exp_a;
    logic [3:0] exp_be;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); m_lock[k] = 0; m_last[k] = 2; m_err[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_read = ($urandom_range(0, 2) != 0);
      i_address = $urandom;
      g = $urandom_range(0, 2);
      d_read = (g == 1); d_write = (g == 2);
      d_address = $urandom; d_writedata = $urandom;
      d_byteenable = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        m_waitrequest[k] = ($urandom_range(0, 2) == 0);
        m_readdatavalid[k] = (mq[k].size() > 0) && ($urandom_range(0, 2) == 0);
        m_readdata[k] = $urandom;
      end
      settle();
      for (int k = 0; k < 2; k++) begin
        cap = (mq[k].size() < 4);
        ei = i_read && cap;
        ed = d_write || (d_read && cap);
        if (m_lock[k] != 0)                 g = m_lock[k];
        else if (ei && ed)                  g = (k == 1) ? 2 : ((m_last[k] == 2) ? 1 : 2);
        else if (ei)                        g = 1;
        else if (ed)                        g = 2;
        else                                g = 0;
        rd  = cap && ((g == 1 && i_read) || (g == 2 && d_read));
        wr  = (g == 2) && d_write;
        acc = (rd || wr) && !m_waitrequest[k];
        iv  = m_readdatavalid[k] && mq[k].size() > 0 && mq[k][0] == 1'b0;
        dv  = m_readdatavalid[k] && mq[k].size() > 0 && mq[k][0] == 1'b1;
        exp_c = {rd, wr, !(g == 1 && acc), !(g == 2 && acc), iv, dv, m_err[k]};
        tests++;
        if (ctl(k) !== exp_c) begin
          fails++; $display("FAIL rand_ctl cyc%0d[%0d] got %b exp %b", cyc, k, ctl(k), exp_c);
        end
        if (rd || wr) begin
          exp_a  = (g == 1) ? i_address : d_address;
          exp_be = (g == 1) ? 4'hF : d_byteenable;
          tests++;
          if (m_address[k] !== exp_a || m_byteenable[k] !== exp_be) begin
            fails++; $display("FAIL rand_cmd cyc%0d[%0d] got %h/%h exp %h/%h",
                              cyc, k, m_address[k], m_byteenable[k], exp_a, exp_be);
          end
        end
        if (wr) begin
          tests++;
          if (m_writedata[k] !== d_writedata) begin
            fails++; $display("FAIL rand_wdata cyc%0d[%0d] got %h exp %h", cyc, k, m_writedata[k], d_writedata);
          end
        end
        if (iv || dv) begin
          tests++;
          if ((iv && i_readdata[k] !== m_readdata[k]) || (dv && d_readdata[k] !== m_readdata[k])) begin
            fails++; $display("FAIL rand_rdata cyc%0d[%0d] got %h/%h exp %h",
                              cyc, k, i_readdata[k], d_readdata[k], m_readdata[k]);
          end
        end
        if (m_readdatavalid[k]) begin
          if (mq[k].size() > 0) void'(mq[k].pop_front());
          else                  m_err[k] = 1'b1;
        end
        if (acc && rd) mq[k].push_back(g == 2);
        if (acc)             begin m_last[k] = g; m_lock[k] = 0; end
        else if (rd || wr)   m_lock[k] = g;
        else                 m_lock[k] = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_order_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Two-master to one-slave arbiter for a single shared memory bus: instruction fetch master (I) and load/store master (D), both Avalon-MM style with waitrequest and pipelined reads.
- Sits between the RV32I core's instruction/data ports and a unified memory or bus bridge.
- Arbitrates commands, holds grant while the slave stalls, and tracks outstanding read ownership so in-order responses return to the correct master.

Parameters:
- DATA_PRIORITY, 0, 1 = D always wins contention; 0 = round robin between I and D.
- LOG2_MAX_OUTSTANDING, 2, log2 of the maximum number of reads issued but not yet returned (default depth 4).

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- i_address  input  32  instruction fetch address
- i_read  input  1  instruction read request
- i_waitrequest  output  1  I command not accepted this cycle
- i_readdata  output  32  read data to I (valid with i_readdatavalid)
- i_readdatavalid  output  1  response for I
- d_address  input  32  load/store address
- d_read  input  1  load request
- d_write  input  1  store request (never together with d_read)
- d_writedata  input  32  store data
- d_byteenable  input  4  store/load byte enables
- d_waitrequest  output  1  D command not accepted this cycle
- d_readdata  output  32  read data to D
- d_readdatavalid  output  1  response for D
- m_address  output  32  shared bus address
- m_read  output  1  shared bus read
- m_write  output  1  shared bus write
- m_writedata  output  32  shared bus write data
- m_byteenable  output  4  shared bus byte enables (4'hF for I reads)
- m_waitrequest  input  1  slave stall
- m_readdata  input  32  slave read data
- m_readdatavalid  input  1  slave response, in issue order
- rsp_error  output  1  sticky: response received with no outstanding read

Behaviour:
- Request terms: req_i = i_read; req_d = d_read | d_write.
- Read capacity: rd_ok = tag FIFO not full. A pop in the same cycle does not free capacity, so there is no combinational path from m_readdatavalid to m_read.
- A master is eligible when it is requesting and, for a read, rd_ok is true. D writes are eligible regardless of rd_ok.
- State machine: IDLE, LOCK_I, LOCK_D.
- IDLE:
  - If only one master is eligible, it is granted.
  - If both are eligible: DATA_PRIORITY=1 grants D; DATA_PRIORITY=0 grants the master not granted last (rr pointer).
  - The grant drives m_* combinationally in the same cycle (zero-latency pass-through).
  - accept = (m_read | m_write) & ~m_waitrequest.
  - If granted and not accepted, go to LOCK_x.
- LOCK_x:
  - m_* stay sourced from master x; no re-arbitration.
  - The master must hold its command stable (Avalon rule).
  - Return to IDLE on accept; next arbitration happens the following cycle.
  - If the master drops its request while locked, m_read/m_write deassert and the FSM returns to IDLE (protocol violation tolerated, not flagged).
- Requester waitrequest:
  - x_waitrequest = ~(grant==x & accept).
  - Asserted whenever x is idle or blocked, including when the FIFO is full.
- rr pointer: updates to the granted master on each accept, in both priority modes.
- Tag FIFO:
  - Depth 2^LOG2_MAX_OUTSTANDING, 1-bit owner tag (0=I, 1=D).
  - Push on an accepted read; pop on m_readdatavalid.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo depth.
- Response routing:
  - i_readdata = d_readdata = m_readdata (broadcast).
  - x_readdatavalid = m_readdatavalid & !empty & head_tag==x, combinational, same cycle.
- Unexpected response: m_readdatavalid with an empty FIFO is dropped and sets rsp_error, which clears only on reset.
- Reset (synchronous, while reset=1):
  - State IDLE, FIFO empty, rr pointer = D (so I wins the first contention in round robin), rsp_error=0.
  - m_read=0, m_write=0, i_waitrequest=1, d_waitrequest=1, both readdatavalid=0.
  - m_address, m_writedata and m_byteenable are don't-care, driven from D inputs.
- Reset mid-operation: in-flight tags are discarded. Late responses after reset set rsp_error and are not forwarded.

Decomposition:
- Shared package rv32i_arb_pkg: state encodings (ARB_IDLE, ARB_LOCK_I, ARB_LOCK_D), tag constants TAG_I=0 / TAG_D=1, I-fetch byteenable constant 4'hF.
- One sub-module, rv32i_arb_tag_fifo: parameterised-depth 1-bit FIFO with push, pop, full, empty and head outputs, synchronous active-high reset.

Test Plan:
- Single I read, slave waitrequest=0: i_read=1, i_address=32'h100 → m_read=1 and m_address=32'h100 in the same cycle, i_waitrequest=0. When m_readdatavalid=1 with m_readdata=32'h00000013 two cycles later, i_readdatavalid=1 and d_readdatavalid=0.
- Contention with DATA_PRIORITY=1: i_read and d_write (addr 32'h2000, data 32'hDEADBEEF, be 4'h3) in the same cycle → D granted first with m_byteenable=4'h3. I is accepted the next cycle with m_byteenable=4'hF.
- Round robin with DATA_PRIORITY=0: I and D both request continuously for 6 accepts → grant order I,D,I,D,I,D.
- Lock: D read granted with m_waitrequest=1 for 3 cycles while i_read is held → m_* held on D for all 3 cycles, i_waitrequest=1, no switch. D is accepted on cycle 4 and I on cycle 5.
- Full FIFO (depth 4): 4 I reads accepted with no responses → 5th read gets i_waitrequest=1 and m_read=0, even in a cycle where m_readdatavalid=1. The read issues the next cycle. A D write still issues while the FIFO is full.
- Mixed ordering and reset: issue I, D, I reads, then return 3 responses → valids route I, D, I in order. Assert reset with 2 reads outstanding, then drive m_readdatavalid after reset → neither master's readdatavalid asserts and rsp_error=1.
